led_fade_ctrl: RTL and testbench

Multi-channel LED fade controller that sequences the duty cycles compared against the shared free-running 8-bit ramp counter. It accepts brightness commands over a valid/ready handshake. Commands are applied only at PWM period boundaries. Duties step linearly toward each channel's target at a programmable per-channel rate, and the block drives the registered PWM outputs to the LED pins.

---
 rtl/led_fade_ctrl.sv | 126 ++++++++++++
 tb/tb_led_fade_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_ctrl.sv
// Multi-channel LED fade controller: duties step toward per-channel targets at PWM period
// boundaries, and the shared ramp is compared against each duty to drive registered PWM pins.
module led_fade_ctrl #(
    parameter int  NCHAN  = 4,
    parameter int  RATE_W = 4,
    localparam int CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ramp,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CW-1:0]     cmd_chan,
    input  logic [7:0]        cmd_target,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [NCHAN-1:0]  pwm,
    output logic              busy,
    output logic [NCHAN-1:0]  fade_done
);

    logic [7:0]        duty_q   [NCHAN];
    logic [7:0]        duty_d   [NCHAN];
    logic [7:0]        target_q [NCHAN];
    logic [7:0]        target_d [NCHAN];
    logic [RATE_W-1:0] rate_q   [NCHAN];
    logic [RATE_W-1:0] rate_d   [NCHAN];
    logic [RATE_W-1:0] div_q    [NCHAN];
    logic [RATE_W-1:0] div_d    [NCHAN];

    logic              pending_q, pending_d;
    logic [CW-1:0]     pchan_q, pchan_d;
    logic [7:0]        ptarget_q, ptarget_d;
    logic [RATE_W-1:0] prate_q, prate_d;
    logic [NCHAN-1:0]  pwm_q, pwm_d;
    logic [NCHAN-1:0]  done_q, done_d;

    logic period_end;
    logic apply_now;

    assign period_end = (ramp == 8'hFF);
    // pending_q is a register, so a command accepted on a wrap edge waits a full period
    assign apply_now  = period_end && pending_q;

    always_comb begin
        pending_d = pending_q;
        pchan_d   = pchan_q;
        ptarget_d = ptarget_q;
        prate_d   = prate_q;
        duty_d    = duty_q;
        target_d  = target_q;
        rate_d    = rate_q;
        div_d     = div_q;
        pwm_d     = '0;
        done_d    = '0;

        if (cmd_valid && !pending_q) begin
            pending_d = 1'b1;
            pchan_d   = cmd_chan;
            ptarget_d = cmd_target;
            prate_d   = cmd_rate;
        end else if (apply_now) begin
            pending_d = 1'b0;
        end

        for (int i = 0; i < NCHAN; i++) begin
            pwm_d[i] = (ramp < duty_q[i]);
            // Channel indices beyond NCHAN never match and are dropped here
            if (apply_now && (pchan_q == CW'(i))) begin
                target_d[i] = ptarget_q;
                rate_d[i]   = prate_q;
                div_d[i]    = '0;
                if (prate_q == '0) begin
                    duty_d[i] = ptarget_q;
                end
            end else if (period_end && (duty_q[i] != target_q[i])) begin
                if (div_q[i] == rate_q[i]) begin
                    div_d[i]  = '0;
                    duty_d[i] = (duty_q[i] < target_q[i]) ? duty_q[i] + 8'd1 : duty_q[i] - 8'd1;
                    done_d[i] = (duty_d[i] == target_q[i]);
                end else begin
                    div_d[i] = div_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                duty_q[i]   <= '0;
                target_q[i] <= '0;
                rate_q[i]   <= '0;
                div_q[i]    <= '0;
            end
            pending_q <= 1'b0;
            pchan_q   <= '0;
            ptarget_q <= '0;
            prate_q   <= '0;
            pwm_q     <= '0;
            done_q    <= '0;
        end else begin
            duty_q    <= duty_d;
            target_q  <= target_d;
            rate_q    <= rate_d;
            div_q     <= div_d;
            pending_q <= pending_d;
            pchan_q   <= pchan_d;
            ptarget_q <= ptarget_d;
            prate_q   <= prate_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        busy = pending_q;
        for (int i = 0; i < NCHAN; i++) begin
            busy = busy | (duty_q[i] != target_q[i]);
        end
    end

    assign cmd_ready = !pending_q;
    assign pwm       = pwm_q;
    assign fade_done = done_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Bench for led_fade_ctrl: directed scenarios plus random commands against a period-level model.
module tb_led_fade_ctrl;

    localparam int NCHAN  = 4;
    localparam int RATE_W = 4;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic [7:0]        ramp       = 8'd0;
    logic              cmd_valid  = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_chan   = 2'd0;
    logic [7:0]        cmd_target = 8'd0;
    logic [RATE_W-1:0] cmd_rate   = '0;
    logic [NCHAN-1:0]  pwm;
    logic              busy;
    logic [NCHAN-1:0]  fade_done;

    int n_checks = 0;
    int n_fail   = 0;
    int per_cnt  [NCHAN];
    int per_done [NCHAN];

    // Reference model state: duty/target as integers, m_wait counts periods until the next step
    int         m_duty [NCHAN];
    int         m_tgt  [NCHAN];
    int         m_rate [NCHAN];
    int         m_wait [NCHAN];
    bit         m_pend = 1'b0;
    bit         m_acc;
    int         m_pch, m_ptg, m_prt;
    logic [NCHAN-1:0] m_pwm  = '0;
    logic [NCHAN-1:0] m_done = '0;

    led_fade_ctrl #(.NCHAN(NCHAN), .RATE_W(RATE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ramp       (ramp),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_target (cmd_target),
        .cmd_rate   (cmd_rate),
        .pwm        (pwm),
        .busy       (busy),
        .fade_done  (fade_done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        ramp = ramp + 8'd1;
    end

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                m_duty[i] = 0; m_tgt[i] = 0; m_rate[i] = 0; m_wait[i] = 1;
            end
            m_pend = 1'b0;
            m_pwm  = '0;
            m_done = '0;
        end else begin
            m_acc  = cmd_valid && !m_pend;
            m_done = '0;
            for (int i = 0; i < NCHAN; i++) m_pwm[i] = (int'(ramp) < m_duty[i]);
            if (ramp == 8'd255) begin
                for (int i = 0; i < NCHAN; i++) begin
                    if (m_pend && m_pch == i) begin
                        m_tgt[i]  = m_ptg;
                        m_rate[i] = m_prt;
                        m_wait[i] = m_prt + 1;
                        if (m_prt == 0) m_duty[i] = m_ptg;
                    end else if (m_duty[i] != m_tgt[i]) begin
                        m_wait[i] = m_wait[i] - 1;
                        if (m_wait[i] == 0) begin
                            m_duty[i] = m_duty[i] + ((m_tgt[i] > m_duty[i]) ? 1 : -1);
                            m_wait[i] = m_rate[i] + 1;
                            if (m_duty[i] == m_tgt[i]) m_done[i] = 1'b1;
                        end
                    end
                end
                m_pend = 1'b0;
            end
            if (m_acc) begin
                m_pend = 1'b1;
                m_pch  = int'(cmd_chan);
                m_ptg  = int'(cmd_target);
                m_prt  = int'(cmd_rate);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    // Returns 2 time units after a rising edge; ramp then holds the value for the next edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ramp(input logic [7:0] v);
        for (int k = 0; k < 300 && ramp != v; k++) step();
        if (ramp !== v) begin
            n_checks++; n_fail++;
            $display("FAIL wait_ramp: ramp=%0d required %0d", ramp, v);
        end
    endtask

    task automatic run_period();
        for (int i = 0; i < NCHAN; i++) begin per_cnt[i] = 0; per_done[i] = 0; end
        for (int k = 0; k < 256; k++) begin
            step();
            if (k == 0) cmd_valid = 1'b0;
            for (int i = 0; i < NCHAN; i++) begin
                per_cnt[i]  += int'(pwm[i]);
                per_done[i] += int'(fade_done[i]);
            end
        end
    endtask

    task automatic send(input int ch, input int tgt, input int rate);
        cmd_chan   = 2'(ch);
        cmd_target = 8'(tgt);
        cmd_rate   = RATE_W'(rate);
        cmd_valid  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++; if (pwm !== '0) begin n_fail++; $display("FAIL reset_pwm: got %b want 0000", pwm); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (fade_done !== '0) begin n_fail++; $display("FAIL reset_done: got %b want 0000", fade_done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_jump();
        int err, dn;
        wait_ramp(8'd10);
        send(1, 64, 0);
        step();
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL jump_accept_ready: got %b want 0", cmd_ready); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL jump_pending_busy: got %b want 1", busy); end
        err = 0;
        for (int k = 0; k < 300 && ramp != 8'd255; k++) begin
            step();
            if (cmd_ready !== 1'b0) err++;
        end
        n_checks++; if (err != 0) begin n_fail++; $display("FAIL jump_ready_held: %0d cycles ready high, want 0", err); end
        step();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL jump_apply_ready: got %b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL jump_apply_busy: got %b want 0", busy); end
        err = 0; dn = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (pwm[1] !== ((k < 64) ? 1'b1 : 1'b0)) err++;
            dn += int'(fade_done[1]);
        end
        n_checks++; if (err != 0) begin n_fail++; $display("FAIL jump_pwm_shape: %0d wrong cycles, want 0", err); end
        n_checks++; if (dn != 0) begin n_fail++; $display("FAIL jump_no_done: got %0d pulses want 0", dn); end
    endtask

    task automatic test_fade_up();
        wait_ramp(8'd0);
        send(2, 4, 1);
        run_period();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fadeup_busy_start: got %b want 1", busy); end
        for (int p = 1; p <= 8; p++) begin
            run_period();
            n_checks++; if (per_cnt[2] != (p - 1) / 2) begin n_fail++; $display("FAIL fadeup_duty p=%0d: got %0d want %0d", p, per_cnt[2], (p - 1) / 2); end
            n_checks++; if (per_done[2] != ((p == 8) ? 1 : 0)) begin n_fail++; $display("FAIL fadeup_done p=%0d: got %0d want %0d", p, per_done[2], (p == 8) ? 1 : 0); end
            n_checks++; if (busy !== ((p == 8) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL fadeup_busy p=%0d: got %b want %b", p, busy, (p != 8)); end
        end
        run_period();
        n_checks++; if (per_cnt[2] != 4) begin n_fail++; $display("FAIL fadeup_final: got %0d want 4", per_cnt[2]); end
        n_checks++; if (per_done[2] != 0) begin n_fail++; $display("FAIL fadeup_extra_done: got %0d want 0", per_done[2]); end
    endtask

    task automatic test_retarget();
        int err, tot;
        wait_ramp(8'd0);
        send(3, 10, 1);
        run_period();
        err = 0;
        for (int p = 1; p <= 10; p++) begin
            run_period();
            if (per_cnt[3] != (p - 1) / 2) err++;
        end
        n_checks++; if (err != 0) begin n_fail++; $display("FAIL retarget_rampup: %0d wrong periods want 0", err); end
        send(3, 2, 2);
        run_period();
        n_checks++; if (per_cnt[3] != 5) begin n_fail++; $display("FAIL retarget_at5: got %0d want 5", per_cnt[3]); end
        tot = 0;
        for (int q = 1; q <= 9; q++) begin
            run_period();
            tot += per_done[3];
            n_checks++; if (per_cnt[3] != 5 - (q - 1) / 3) begin n_fail++; $display("FAIL retarget_duty q=%0d: got %0d want %0d", q, per_cnt[3], 5 - (q - 1) / 3); end
        end
        n_checks++; if (per_done[3] != 1) begin n_fail++; $display("FAIL retarget_done_last: got %0d want 1", per_done[3]); end
        n_checks++; if (tot != 1) begin n_fail++; $display("FAIL retarget_done_total: got %0d want 1", tot); end
        run_period();
        n_checks++; if (per_cnt[3] != 2) begin n_fail++; $display("FAIL retarget_final: got %0d want 2", per_cnt[3]); end
    endtask

    task automatic test_back_to_back();
        int err, dn0;
        // held command while pending must not be accepted twice
        wait_ramp(8'd20);
        send(0, 30, 0);
        step();
        err = 0;
        for (int k = 0; k < 300 && ramp != 8'd255; k++) begin
            cmd_target = 8'd99;
            step();
            if (cmd_ready !== 1'b0) err++;
        end
        n_checks++; if (err != 0) begin n_fail++; $display("FAIL hold_ready: %0d cycles ready high want 0", err); end
        step();
        cmd_valid = 1'b0;
        run_period();
        n_checks++; if (per_cnt[0] != 30) begin n_fail++; $display("FAIL hold_duty: got %0d want 30", per_cnt[0]); end
        // accept on a wrap edge: applies one full period later
        wait_ramp(8'd255);
        send(0, 100, 0);
        step();
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_accept: got %b want 0", cmd_ready); end
        repeat (255) step();
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_wait255: got %b want 0", cmd_ready); end
        step();
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_apply256: got %b want 1", cmd_ready); end
        run_period();
        n_checks++; if (per_cnt[0] != 100) begin n_fail++; $display("FAIL wrap_duty: got %0d want 100", per_cnt[0]); end
        // ch0 apply lands on the same wrap edge as a ch1 step
        wait_ramp(8'd0);
        send(1, 62, 1);
        run_period();
        run_period();
        send(0, 10, 0);
        run_period();
        dn0 = per_done[0];
        run_period();
        dn0 += per_done[0];
        n_checks++; if (per_cnt[0] != 10) begin n_fail++; $display("FAIL coinc_ch0: got %0d want 10", per_cnt[0]); end
        n_checks++; if (per_cnt[1] != 63) begin n_fail++; $display("FAIL coinc_ch1: got %0d want 63", per_cnt[1]); end
        run_period();
        dn0 += per_done[0];
        n_checks++; if (per_done[1] != 1) begin n_fail++; $display("FAIL coinc_ch1_done: got %0d want 1", per_done[1]); end
        run_period();
        dn0 += per_done[0];
        n_checks++; if (per_cnt[1] != 62) begin n_fail++; $display("FAIL coinc_ch1_final: got %0d want 62", per_cnt[1]); end
        n_checks++; if (dn0 != 0) begin n_fail++; $display("FAIL coinc_ch0_done: got %0d want 0", dn0); end
    endtask

    task automatic test_reset_mid();
        int sum, dn;
        wait_ramp(8'd0);
        send(2, 200, 3);
        run_period();
        send(3, 100, 3);
        run_period();
        run_period();
        send(0, 77, 0);
        step();
        cmd_valid = 1'b0;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pending: got %b want 0", cmd_ready); end
        rst_n = 1'b0;
        step();
        n_checks++; if (pwm !== '0) begin n_fail++; $display("FAIL rmid_pwm: got %b want 0000", pwm); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", cmd_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        sum = 0; dn = 0;
        for (int r = 0; r < 2; r++) begin
            run_period();
            for (int i = 0; i < NCHAN; i++) begin sum += per_cnt[i]; dn += per_done[i]; end
        end
        n_checks++; if (sum != 0) begin n_fail++; $display("FAIL rmid_duties: got %0d high cycles want 0", sum); end
        n_checks++; if (dn != 0) begin n_fail++; $display("FAIL rmid_done: got %0d pulses want 0", dn); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_random();
        int   c, t;
        logic exp_busy;
        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 47) == 0) begin
                c = int'($urandom_range(0, NCHAN - 1));
                t = m_duty[c] + int'($urandom_range(0, 10)) - 5;
                if (t < 0) t = 0;
                if (t > 255) t = 255;
                send(c, t, int'($urandom_range(0, 3)));
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            exp_busy = m_pend;
            for (int i = 0; i < NCHAN; i++) if (m_duty[i] != m_tgt[i]) exp_busy = 1'b1;
            n_checks++; if (pwm !== m_pwm) begin n_fail++; $display("FAIL rand_pwm k=%0d: got %b want %b", k, pwm, m_pwm); end
            n_checks++; if (cmd_ready !== !m_pend) begin n_fail++; $display("FAIL rand_ready k=%0d: got %b want %b", k, cmd_ready, !m_pend); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy k=%0d: got %b want %b", k, busy, exp_busy); end
            n_checks++; if (fade_done !== m_done) begin n_fail++; $display("FAIL rand_done k=%0d: got %b want %b", k, fade_done, m_done); end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_fade_up();
        test_retarget();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
